// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler and the LCD_CTRL engine bench:
// command codes, scheduler FSM states and default frame geometry.
package lcd_pkg;

    localparam int DEF_IMG_BYTES = 108;
    localparam int DEF_PIX_OUT   = 16;
    localparam int DEF_TIMEOUT   = 64;

    localparam logic [3:0] CMD_LOAD    = 4'd0;
    localparam logic [3:0] CMD_ROT_L   = 4'd1;
    localparam logic [3:0] CMD_ROT_R   = 4'd2;
    localparam logic [3:0] CMD_ZOOM_IN = 4'd3;
    localparam logic [3:0] CMD_FIT     = 4'd4;
    localparam logic [3:0] CMD_SHIFT_R = 4'd5;
    localparam logic [3:0] CMD_SHIFT_L = 4'd6;
    localparam logic [3:0] CMD_SHIFT_U = 4'd7;
    localparam logic [3:0] CMD_SHIFT_D = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FILL,
        ST_ISSUE,
        ST_STREAM,
        ST_COLLECT
    } sched_state_t;

    function automatic logic cmd_legal(input logic [3:0] code);
        return code <= CMD_SHIFT_D;
    endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// LOAD frame store: one synchronous write port and one read port with a
// registered output, so the reader addresses one byte ahead.
module lcd_frame_buf #(
    parameter int DW = 8,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Shares one LCD_CTRL engine between two requesters: round-robin per command,
// buffers and replays LOAD frames, and routes the 16 result pixels back.
module lcd_cmd_scheduler
    import lcd_pkg::*;
#(
    parameter int DW        = 8,
    parameter int IMG_BYTES = DEF_IMG_BYTES,
    parameter int PIX_OUT   = DEF_PIX_OUT,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [7:0]    req_cmd,
    output logic [1:0]    gnt,
    input  logic [2*DW-1:0] ld_data,
    input  logic [1:0]    ld_valid,
    output logic [1:0]    ld_ready,
    output logic [DW-1:0] pix_data,
    output logic [1:0]    pix_valid,
    output logic [1:0]    done,
    output logic [1:0]    err,
    output logic [3:0]    lcd_cmd,
    output logic          lcd_cmd_valid,
    output logic [DW-1:0] lcd_datain,
    input  logic          lcd_busy,
    input  logic [DW-1:0] lcd_dataout,
    input  logic          lcd_output_valid
);

    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [6:0]     LAST_BYTE = 7'(IMG_BYTES - 1);
    localparam logic [4:0]     LAST_BEAT = 5'(PIX_OUT - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);

    sched_state_t   state, state_nxt;
    logic           winner, last_gnt, pick;
    logic [1:0]     win_mask;
    logic [3:0]     win_cmd, cmd;
    logic [6:0]     fill_cnt, stream_cnt, rd_addr;
    logic [4:0]     beat_cnt;
    logic [WDW-1:0] wdog;
    logic           wr_en, accept, beat, done_set, err_set;
    logic [DW-1:0]  wr_data, rd_data;

    assign win_mask = winner ? 2'b10 : 2'b01;
    assign win_cmd  = winner ? req_cmd[7:4] : req_cmd[3:0];
    assign wr_data  = winner ? ld_data[2*DW-1:DW] : ld_data[DW-1:0];
    // On a tie the requester not granted last wins; a lone requester always wins.
    assign pick     = (req == 2'b11) ? ~last_gnt : req[1];

    assign wr_en  = (state == ST_FILL) && ld_valid[winner];
    assign accept = (state == ST_ISSUE) && !lcd_busy;
    assign beat   = (state == ST_COLLECT) && lcd_output_valid;
    // Read one byte ahead so the registered output holds byte k in stream cycle k.
    assign rd_addr = (state == ST_STREAM) ? stream_cnt + 7'd1 : 7'd0;

    assign gnt           = (state != ST_IDLE) ? win_mask : 2'b00;
    assign ld_ready      = (state == ST_FILL) ? win_mask : 2'b00;
    assign lcd_cmd       = (state == ST_ISSUE) ? cmd : 4'd0;
    assign lcd_cmd_valid = accept;
    assign lcd_datain    = (state == ST_STREAM) ? rd_data : '0;
    assign pix_data      = beat ? lcd_dataout : '0;
    assign pix_valid     = beat ? win_mask : 2'b00;

    lcd_frame_buf #(.DW(DW), .AW(7)) u_frame_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (fill_cnt),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (!cmd_legal(win_cmd)) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (win_cmd == CMD_LOAD) begin
                    state_nxt = ST_FILL;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_FILL: begin
                if (wr_en && fill_cnt == LAST_BYTE) begin
                    state_nxt = ST_ISSUE;
                end else if (!req[winner]) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept) state_nxt = (cmd == CMD_LOAD) ? ST_STREAM : ST_COLLECT;
            end
            ST_STREAM: begin
                if (stream_cnt == LAST_BYTE) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (beat && beat_cnt == LAST_BEAT) begin
                    done_set  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!beat && wdog == WD_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration pointer, captured command, counters, watchdog and result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner     <= 1'b0;
            last_gnt   <= 1'b1;
            cmd        <= 4'd0;
            fill_cnt   <= 7'd0;
            stream_cnt <= 7'd0;
            beat_cnt   <= 5'd0;
            wdog       <= '0;
            done       <= 2'b00;
            err        <= 2'b00;
        end else begin
            if (state == ST_IDLE && req != 2'b00) begin
                winner   <= pick;
                last_gnt <= pick;
            end
            if (state == ST_GRANT) begin
                cmd      <= win_cmd;
                fill_cnt <= 7'd0;
            end else if (wr_en) begin
                fill_cnt <= fill_cnt + 7'd1;
            end
            stream_cnt <= (state == ST_STREAM) ? stream_cnt + 7'd1 : 7'd0;
            if (state != ST_COLLECT) begin
                beat_cnt <= 5'd0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 5'd1;
            end
            wdog <= (state != ST_COLLECT || beat) ? '0 : wdog + WDW'(1);
            done <= done_set ? win_mask : 2'b00;
            err  <= err_set ? win_mask : 2'b00;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: arbitration, LOAD fill/stream, illegal
// commands, busy engine, watchdog timeout and asynchronous reset mid-stream.
module tb_lcd_cmd_scheduler;
    import lcd_pkg::*;

    localparam int DW        = 8;
    localparam int IMG_BYTES = DEF_IMG_BYTES;
    localparam int PIX_OUT   = DEF_PIX_OUT;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [7:0]      req_cmd;
    logic [1:0]      gnt;
    logic [2*DW-1:0] ld_data;
    logic [1:0]      ld_valid, ld_ready;
    logic [DW-1:0]   pix_data;
    logic [1:0]      pix_valid, done, err;
    logic [3:0]      lcd_cmd;
    logic            lcd_cmd_valid;
    logic [DW-1:0]   lcd_datain;
    logic            lcd_busy;
    logic [DW-1:0]   lcd_dataout;
    logic            lcd_output_valid;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] frame [IMG_BYTES];

    lcd_cmd_scheduler #(.DW(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_cmd          (req_cmd),
        .gnt              (gnt),
        .ld_data          (ld_data),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .done             (done),
        .err              (err),
        .lcd_cmd          (lcd_cmd),
        .lcd_cmd_valid    (lcd_cmd_valid),
        .lcd_datain       (lcd_datain),
        .lcd_busy         (lcd_busy),
        .lcd_dataout      (lcd_dataout),
        .lcd_output_valid (lcd_output_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] onehot(input int who);
        return (who != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [31:0] allOutputs();
        return {1'b0, gnt, ld_ready, pix_valid, done, err, lcd_cmd, lcd_cmd_valid,
                lcd_datain, pix_data};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [7:0] c);
        @(negedge clk);
        req     = r;
        req_cmd = c;
        #1;
    endtask

    task automatic fillFrame(input int seed);
        for (int k = 0; k < IMG_BYTES; k++) frame[k] = 8'((k * seed + 17) & 255);
    endtask

    task automatic waitGrant(input int who, input string tag);
        int n = 0;
        while (gnt == 2'b00 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'(gnt), 32'(onehot(who)));
    endtask

    task automatic waitIssue(input logic [3:0] code, input string tag);
        int n = 0;
        while (lcd_cmd_valid !== 1'b1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'({lcd_cmd_valid, lcd_cmd}), 32'({1'b1, code}));
    endtask

    task automatic collectBeats(input int who, input int count, input string tag);
        for (int i = 0; i < count; i++) begin
            logic [DW-1:0] d;
            d = 8'(8'h30 + i * 7);
            @(negedge clk);
            lcd_output_valid = 1'b1;
            lcd_dataout      = d;
            #1;
            checkOutput({tag, "_pix_valid"}, 32'({lcd_cmd_valid, pix_valid}),
                        32'({1'b0, onehot(who)}));
            checkOutput({tag, "_pix_data"}, 32'(pix_data), 32'(d));
        end
        @(negedge clk);
        lcd_output_valid = 1'b0;
        lcd_dataout      = '0;
        #1;
    endtask

    task automatic checkDone(input int who, input string tag);
        checkOutput({tag, "_done"}, 32'({done, gnt, err}), 32'({onehot(who), 4'b0000}));
        @(negedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'h0);
    endtask

    // Full LOAD transaction; abort_at < IMG_BYTES pulls reset during that stream byte.
    task automatic runLoad(input int who, input bit gaps, input int abort_at, input string tag);
        int idx = 0;
        int n   = 0;
        applyStimulus(onehot(who), 8'h00);
        waitGrant(who, {tag, "_gnt"});
        while (idx < IMG_BYTES && n < 2000) begin
            @(negedge clk);
            ld_valid = 2'b00;
            if (!gaps || $urandom_range(0, 2) != 0) ld_valid[who] = 1'b1;
            ld_data = '0;
            ld_data[who*DW +: DW] = frame[idx];
            #1;
            if (ld_valid[who] && ld_ready[who]) idx++;
            n++;
        end
        checkOutput({tag, "_fill_bytes"}, 32'(idx), 32'(IMG_BYTES));
        @(negedge clk);
        ld_valid = 2'b00;
        ld_data  = '0;
        #1;
        waitIssue(CMD_LOAD, {tag, "_issue"});
        req = 2'b00;
        for (int k = 0; k < IMG_BYTES; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                checkOutput({tag, "_async_reset"}, allOutputs(), 32'h0);
                return;
            end
            lcd_output_valid = (k < 3);
            lcd_dataout      = 8'hEE;
            #1;
            checkOutput({tag, "_datain"}, 32'(lcd_datain), 32'(frame[k]));
            if (k < 3) checkOutput({tag, "_early_beat"}, 32'(pix_valid), 32'h0);
        end
        @(negedge clk);
        lcd_output_valid = 1'b0;
        lcd_dataout      = '0;
        #1;
        checkOutput({tag, "_datain_idle"}, 32'(lcd_datain), 32'h0);
        collectBeats(who, PIX_OUT, tag);
        checkDone(who, tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        reset            = 1'b0;
        req              = 2'b00;
        req_cmd          = 8'h00;
        ld_data          = '0;
        ld_valid         = 2'b00;
        lcd_busy         = 1'b0;
        lcd_dataout      = '0;
        lcd_output_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("idle_after_release", allOutputs(), 32'h0);

        // Both requesting ROT_R: grants must alternate 0,1,0,1 from a fresh pointer.
        applyStimulus(2'b11, {CMD_ROT_R, CMD_ROT_R});
        for (int i = 0; i < 4; i++) begin
            waitGrant(i % 2, "t2_gnt");
            if (i == 3) req = 2'b00;
            waitIssue(CMD_ROT_R, "t2_issue");
            collectBeats(i % 2, PIX_OUT, "t2");
            checkDone(i % 2, "t2");
        end

        fillFrame(3);
        runLoad(0, 1'b1, IMG_BYTES, "t1");

        applyStimulus(2'b10, {4'd12, 4'd0});
        waitGrant(1, "t3_gnt");
        req = 2'b00;
        checkOutput("t3_no_cmd_grant", 32'(lcd_cmd_valid), 32'h0);
        @(negedge clk); #1;
        checkOutput("t3_err", 32'({err, gnt, done, lcd_cmd_valid}),
                    32'({2'b10, 2'b00, 2'b00, 1'b0}));
        @(negedge clk); #1;
        checkOutput("t3_err_pulse", 32'({err, lcd_cmd_valid}), 32'h0);

        lcd_busy = 1'b1;
        applyStimulus(2'b01, {4'd0, CMD_ROT_L});
        waitGrant(0, "t4_gnt");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checkOutput("t4_hold", 32'({gnt, lcd_cmd}), 32'({2'b01, CMD_ROT_L}));
        end
        @(negedge clk);
        lcd_busy = 1'b0;
        #1;
        checkOutput("t4_accept", 32'({lcd_cmd_valid, lcd_cmd}), 32'({1'b1, CMD_ROT_L}));
        req = 2'b00;
        collectBeats(0, PIX_OUT, "t4");
        checkDone(0, "t4");

        applyStimulus(2'b10, {CMD_FIT, 4'd0});
        waitGrant(1, "t5_gnt");
        waitIssue(CMD_FIT, "t5_issue");
        req = 2'b00;
        collectBeats(1, 10, "t5");
        n = 1;
        while (err == 2'b00 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("t5_wd_cycles", 32'(n), 32'd65);
        checkOutput("t5_err", 32'({err, gnt, done}), 32'({2'b10, 2'b00, 2'b00}));
        applyStimulus(2'b01, {4'd0, CMD_SHIFT_U});
        waitGrant(0, "t5b_gnt");
        waitIssue(CMD_SHIFT_U, "t5b_issue");
        req = 2'b00;
        collectBeats(0, PIX_OUT, "t5b");
        checkDone(0, "t5b");

        fillFrame(5);
        runLoad(0, 1'b0, 50, "t6");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t6_reset_hold", allOutputs(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        fillFrame(9);
        runLoad(0, 1'b1, IMG_BYTES, "t6_reload");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
